// File: rtl/proc_io_ctrl.sv
// proc_io_ctrl: buffers source samples into NCH input FIFOs that a processor
// pops on request, and collects processor results, tagged with their channel,
// in one output FIFO that the sink drains.
//
// Ports
//   clk, rst                       single clock, synchronous active-high reset
//   src_valid/src_ch/src_data      source beat, accepted when src_ready is high
//   src_ready                      combinational accept for the addressed channel
//   req_in                         one-hot pop request per input channel
//   in/in_valid                    registered popped sample and its qualifier
//   out_en/io_out                  one-hot write strobe and processor result
//   sink_valid/sink_ch/sink_data   first-word-fall-through output FIFO head
//   sink_ready                     sink accepts the head
//   err                            sticky flags [0] underflow [1] overflow [2] multi-hot
module proc_io_ctrl #(
    parameter int DW    = 32,
    parameter int NCH   = 2,
    parameter int DEPTH = 16,
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           src_valid,
    input  logic [CW-1:0]  src_ch,
    input  logic [DW-1:0]  src_data,
    output logic           src_ready,
    input  logic [NCH-1:0] req_in,
    output logic [DW-1:0]  in,
    output logic           in_valid,
    input  logic [NCH-1:0] out_en,
    input  logic [DW-1:0]  io_out,
    output logic           sink_valid,
    output logic [CW-1:0]  sink_ch,
    output logic [DW-1:0]  sink_data,
    input  logic           sink_ready,
    output logic [2:0]     err
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // Occupancy update shared by every FIFO; push and pop together hold the count.
    function automatic logic [AW:0] next_cnt(input logic [AW:0] cnt, input logic push, input logic pop);
        logic [AW:0] res;
        case ({push, pop})
            2'b10:   res = cnt + {{AW{1'b0}}, 1'b1};
            2'b01:   res = cnt - {{AW{1'b0}}, 1'b1};
            default: res = cnt;
        endcase
        return res;
    endfunction

    logic [DW-1:0]    in_mem_q  [NCH][DEPTH];
    logic [AW-1:0]    in_wr_q   [NCH];
    logic [AW-1:0]    in_wr_d   [NCH];
    logic [AW-1:0]    in_rd_q   [NCH];
    logic [AW-1:0]    in_rd_d   [NCH];
    logic [AW:0]      in_cnt_q  [NCH];
    logic [AW:0]      in_cnt_d  [NCH];
    logic [CW+DW-1:0] out_mem_q [DEPTH];
    logic [AW-1:0]    out_wr_q, out_wr_d;
    logic [AW-1:0]    out_rd_q, out_rd_d;
    logic [AW:0]      out_cnt_q, out_cnt_d;
    logic [DW-1:0]    in_q, in_d;
    logic             in_valid_q, in_valid_d;
    logic [2:0]       err_q, err_d;

    logic             src_ready_s;
    logic [NCH-1:0]   push_s;
    logic [NCH-1:0]   pop_s;
    logic             out_push_s;
    logic             out_pop_s;
    logic [CW-1:0]    out_ch_s;
    logic [CW+DW-1:0] out_head_s;

    // Source accept: channel must exist and its FIFO must not be full before this edge.
    always_comb begin
        src_ready_s = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            src_ready_s = src_ready_s | ((src_ch == CW'(c)) && (in_cnt_q[c] != FULL_CNT));
        end
    end

    // Next-state logic for both FIFO sides, the processor sample register and the flags.
    always_comb begin
        in_wr_d    = in_wr_q;
        in_rd_d    = in_rd_q;
        in_cnt_d   = in_cnt_q;
        in_d       = in_q;
        in_valid_d = 1'b0;
        err_d      = err_q;
        push_s     = '0;
        pop_s      = '0;
        out_ch_s   = '0;
        out_push_s = 1'b0;

        for (int c = 0; c < NCH; c++) begin
            push_s[c] = src_valid && src_ready_s && (src_ch == CW'(c));
        end

        // A pop to an empty FIFO never sees a same-cycle push: the head read uses pre-edge count.
        if ($onehot(req_in)) begin
            for (int c = 0; c < NCH; c++) begin
                if (req_in[c] && (in_cnt_q[c] != '0)) begin
                    pop_s[c]   = 1'b1;
                    in_d       = in_mem_q[c][in_rd_q[c]];
                    in_valid_d = 1'b1;
                end else if (req_in[c]) begin
                    err_d[0] = 1'b1;
                end else begin
                    pop_s[c] = 1'b0;
                end
            end
        end else if (req_in != '0) begin
            err_d[2] = 1'b1;
        end else begin
            in_valid_d = 1'b0;
        end

        for (int c = 0; c < NCH; c++) begin
            in_wr_d[c]  = push_s[c] ? (in_wr_q[c] + AW'(1)) : in_wr_q[c];
            in_rd_d[c]  = pop_s[c]  ? (in_rd_q[c] + AW'(1)) : in_rd_q[c];
            in_cnt_d[c] = next_cnt(in_cnt_q[c], push_s[c], pop_s[c]);
        end

        for (int c = 0; c < NCH; c++) begin
            out_ch_s = out_ch_s | (out_en[c] ? CW'(c) : '0);
        end

        // Full check uses pre-edge count, so a same-cycle sink pop does not make room.
        if ($onehot(out_en)) begin
            if (out_cnt_q != FULL_CNT) begin
                out_push_s = 1'b1;
            end else begin
                err_d[1] = 1'b1;
            end
        end else if (out_en != '0) begin
            err_d[2] = 1'b1;
        end else begin
            out_push_s = 1'b0;
        end

        out_pop_s = (out_cnt_q != '0) && sink_ready;
        out_wr_d  = out_push_s ? (out_wr_q + AW'(1)) : out_wr_q;
        out_rd_d  = out_pop_s  ? (out_rd_q + AW'(1)) : out_rd_q;
        out_cnt_d = next_cnt(out_cnt_q, out_push_s, out_pop_s);
    end

    // Pointer, count, output and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                in_wr_q[c]  <= '0;
                in_rd_q[c]  <= '0;
                in_cnt_q[c] <= '0;
            end
            out_wr_q   <= '0;
            out_rd_q   <= '0;
            out_cnt_q  <= '0;
            in_q       <= '0;
            in_valid_q <= 1'b0;
            err_q      <= 3'b000;
        end else begin
            in_wr_q    <= in_wr_d;
            in_rd_q    <= in_rd_d;
            in_cnt_q   <= in_cnt_d;
            out_wr_q   <= out_wr_d;
            out_rd_q   <= out_rd_d;
            out_cnt_q  <= out_cnt_d;
            in_q       <= in_d;
            in_valid_q <= in_valid_d;
            err_q      <= err_d;
        end
    end

    // Sample storage; not reset, writes suppressed while rst is high.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (push_s[c] && !rst) begin
                in_mem_q[c][in_wr_q[c]] <= src_data;
            end
        end
        if (out_push_s && !rst) begin
            out_mem_q[out_wr_q] <= {out_ch_s, io_out};
        end
    end

    // Head is gated by valid so stale storage never shows after reset.
    assign out_head_s = out_mem_q[out_rd_q];
    assign src_ready  = src_ready_s;
    assign in         = in_q;
    assign in_valid   = in_valid_q;
    assign err        = err_q;
    assign sink_valid = (out_cnt_q != '0);
    assign sink_ch    = sink_valid ? out_head_s[CW+DW-1:DW] : '0;
    assign sink_data  = sink_valid ? out_head_s[DW-1:0] : '0;
endmodule

// File: doc/proc_io_ctrl.md
PROC_IO_CTRL -- requirements
Module: proc_io_ctrl

Interface
REQ-001 The block SHALL have parameter DW, default 32, sample width in bits (signed two's complement).
REQ-002 The block SHALL have parameter NCH, default 2, number of input channels (2..8).
REQ-003 The block SHALL have parameter DEPTH, default 16, entries per FIFO (power of two, >=2); CW=max(1,clog2(NCH)), AW=clog2(DEPTH).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 src_valid  input  1  source beat valid.
REQ-007 src_ch  input  CW  destination input channel of the source beat.
REQ-008 src_data  input  DW  source sample.
REQ-009 src_ready  output  1  source beat accepted when src_valid&&src_ready.
REQ-010 req_in  input  NCH  processor pop request, one-hot per cycle.
REQ-011 in  output  DW  sample delivered to processor, registered.
REQ-012 in_valid  output  1  one-cycle pulse qualifying in.
REQ-013 out_en  input  NCH  processor write strobe, one-hot, selects output channel tag.
REQ-014 io_out  input  DW  processor result sample.
REQ-015 sink_valid  output  1  output FIFO head valid.
REQ-016 sink_ch  output  CW  channel tag of head.
REQ-017 sink_data  output  DW  data of head.
REQ-018 sink_ready  input  1  sink accepts head when sink_valid&&sink_ready.
REQ-019 err  output  3  sticky flags: [0] underflow, [1] overflow, [2] multi-hot strobe.

Function
REQ-020 The block SHALL contain NCH independent input FIFOs (DEPTH x DW) and one output FIFO (DEPTH x (CW+DW)), each with AW-bit wrapping read/write pointers and an (AW+1)-bit occupancy count.
REQ-021 src_ready SHALL be combinational: 1 iff src_ch<NCH and input FIFO[src_ch] count<DEPTH (pre-edge state); a pop in the same cycle SHALL NOT free space for that cycle's push.
REQ-022 A beat with src_ch>=NCH SHALL be ignored with src_ready=0 and no flag set.
REQ-023 One-hot req_in at channel c with FIFO[c] non-empty SHALL pop the head; in SHALL take the head value and in_valid SHALL be 1 in the following cycle (latency 1).
REQ-024 One-hot req_in at channel c with FIFO[c] empty SHALL NOT pop, SHALL hold in, drive in_valid=0 next cycle, and set err[0]; a same-cycle push to empty FIFO[c] SHALL complete but SHALL NOT bypass.
REQ-025 Multi-hot req_in SHALL perform no pop, set err[2], in_valid=0 next cycle; req_in=0 SHALL give in_valid=0 and hold in.
REQ-026 One-hot out_en at channel c SHALL push {c, io_out} to the output FIFO if count<DEPTH (pre-edge state); if full, the write SHALL be dropped and err[1] set, even when the sink pops the same cycle.
REQ-027 Multi-hot out_en SHALL be dropped and set err[2].
REQ-028 The output FIFO SHALL be first-word-fall-through: sink_valid=(count!=0), sink_ch/sink_data show head combinationally from registered storage; a push at edge k SHALL make sink_valid 1 after edge k when previously empty.
REQ-029 Simultaneous push and pop on any non-full, non-empty FIFO SHALL leave count unchanged and preserve order.
REQ-030 Pointers SHALL wrap DEPTH-1 -> 0 with no data loss; FIFO order SHALL be strictly first-in-first-out per FIFO.
REQ-031 err bits SHALL be sticky, cleared only by rst.

Reset
REQ-032 While rst=1 at an edge, all FIFO pointers/counts SHALL clear, in=0, in_valid=0, err=0; pushes/pops in that cycle SHALL be ignored.
REQ-033 After reset sink_valid=0, sink_ch=0 and src_ready=1 for any src_ch<NCH; rst mid-operation SHALL discard all buffered samples.

Verification
REQ-034 Push 5,-7,9 to ch1; req_in=2'b10 on three consecutive cycles -> in=5,-7,9 with in_valid high one cycle after each request; err=0.
REQ-035 Fill ch0 with DEPTH samples -> src_ready=0 for src_ch=0, 1 for src_ch=1; pop one and push same cycle -> push refused; next cycle push accepted; 2*DEPTH pushes/pops -> order preserved across wrap.
REQ-036 req_in=2'b01 with ch0 empty and same-cycle push of 42 -> in_valid=0, err[0]=1; next req_in=2'b01 -> in=42, in_valid=1.
REQ-037 sink_ready=0, out_en=2'b10 with io_out=1..DEPTH+1 -> first DEPTH stored with sink_ch=1, last dropped, err[1]=1; draining yields 1..DEPTH.
REQ-038 req_in=2'b11 and out_en=2'b11 -> no pop/push, err[2]=1; assert rst with data buffered -> all counts 0, sink_valid=0, in=0, err=0.
